// File: rtl/core_ibex_dii_tracker.sv
// DII tracker: counts injected and retired instructions, queues injected words
// and checks each retired word in order against the oldest queued entry.
module core_ibex_dii_tracker #(
   parameter int unsigned NRET     = 1,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned THROTTLE = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr_i,
   input  logic                       count_en_i,
   input  logic                       instr_ack_i,
   input  logic [31:0]                instr_rdata_i,
   input  logic [NRET-1:0]            rvfi_valid_i,
   input  logic [NRET*32-1:0]         rvfi_insn_i,
   output logic [CNT_W-1:0]           instr_in_o,
   output logic [CNT_W-1:0]           instr_out_o,
   output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
   output logic                       throttle_o,
   output logic                       mismatch_o,
   output logic [$clog2(NRET):0]      mismatch_lane_o,
   output logic [31:0]                mismatch_exp_o,
   output logic [31:0]                mismatch_got_o,
   output logic                       overflow_o,
   output logic                       underflow_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned OW = $clog2(DEPTH+1);
   localparam int unsigned LW = $clog2(NRET) + 1;
   localparam int unsigned CW = OW + 3;

   logic [31:0]   mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [OW-1:0] occ;

   logic [CW-1:0] slot, pops, occ_after, occ_next;
   logic          under, mm_found, push_req, push_ok;
   logic [LW-1:0] mm_lane;
   logic [31:0]   mm_exp, mm_got, head_word;

   // slot walks the valid lanes in ascending order; only pre-cycle entries are visible
   always_comb begin
      slot      = '0;
      under     = 1'b0;
      mm_found  = 1'b0;
      mm_lane   = '0;
      mm_exp    = '0;
      mm_got    = '0;
      head_word = '0;
      for (int unsigned k = 0; k < NRET; k++) begin
         if (rvfi_valid_i[k]) begin
            if (slot < CW'(occ)) begin
               head_word = mem[rd_ptr + PW'(slot)];
               if (!mm_found && head_word != rvfi_insn_i[32*k +: 32]) begin
                  mm_found = 1'b1;
                  mm_lane  = LW'(k);
                  mm_exp   = head_word;
                  mm_got   = rvfi_insn_i[32*k +: 32];
               end
            end else begin
               under = 1'b1;
            end
            slot = slot + CW'(1);
         end
      end
      pops      = under ? CW'(occ) : slot;
      occ_after = CW'(occ) - pops;
      push_req  = count_en_i & instr_ack_i;
      push_ok   = push_req && (occ_after < CW'(DEPTH));
      occ_next  = occ_after + CW'(push_ok);
   end

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         instr_in_o      <= '0;
         instr_out_o     <= '0;
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         occ             <= '0;
         mismatch_o      <= 1'b0;
         mismatch_lane_o <= '0;
         mismatch_exp_o  <= '0;
         mismatch_got_o  <= '0;
         overflow_o      <= 1'b0;
         underflow_o     <= 1'b0;
      end else begin
         if (push_req) instr_in_o <= instr_in_o + CNT_W'(1);
         instr_out_o <= instr_out_o + CNT_W'(slot);
         mismatch_o  <= count_en_i && mm_found;
         if (count_en_i) begin
            rd_ptr <= rd_ptr + PW'(pops);
            occ    <= OW'(occ_next);
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (push_req && !push_ok) overflow_o <= 1'b1;
            if (under) underflow_o <= 1'b1;
            if (mm_found) begin
               mismatch_lane_o <= mm_lane;
               mismatch_exp_o  <= mm_exp;
               mismatch_got_o  <= mm_got;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!(rst || clr_i) && push_ok) mem[wr_ptr] <= instr_rdata_i;
   end

   assign outstanding_o = occ;
   assign throttle_o    = (occ >= OW'(THROTTLE));

endmodule

// File: doc/core_ibex_dii_tracker.md
Name: core_ibex_dii_tracker

Overview:
- Bench-side tracker for direct instruction injection (DII). Counts instructions injected into the core and instructions retired over RVFI.
- Holds injected instruction words in an in-order queue and checks each retired instruction word against the oldest queued entry.
- Flags mismatches, overflow and underflow, and raises a throttle hint to the injection sequence.
- Generalises the single-lane injected/retired counter pair to NRET retire lanes, parametrised counter width, queue depth and in-order checking.

Parameters:
- NRET, 1: number of RVFI retire lanes per cycle (1..4).
- DEPTH, 8: injected-word queue depth (power of 2, >=2).
- CNT_W, 32: width of the injected and retired counters.
- THROTTLE, 6: outstanding level at or above which throttle_o asserts (1..DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clr_i  in  1  synchronous clear; same effect as rst
- count_en_i  in  1  enables injection counting, queue push/pop and checking
- instr_ack_i  in  1  core accepted the injected instruction this cycle
- instr_rdata_i  in  32  injected instruction word, valid with instr_ack_i
- rvfi_valid_i  in  NRET  per-lane retire valid; lane 0 is oldest
- rvfi_insn_i  in  NRET*32  per-lane retired word; lane k at bits [32k+31:32k]
- instr_in_o  out  CNT_W  injected count
- instr_out_o  out  CNT_W  retired count
- outstanding_o  out  $clog2(DEPTH+1)  queue occupancy
- throttle_o  out  1  outstanding_o >= THROTTLE
- mismatch_o  out  1  one-cycle pulse on a compare failure
- mismatch_lane_o  out  $clog2(NRET)+1  lane of the reported mismatch
- mismatch_exp_o  out  32  expected (queued) word
- mismatch_got_o  out  32  retired word
- overflow_o  out  1  sticky: push dropped because the queue was full
- underflow_o  out  1  sticky: retire with no queued entry

Behaviour:
- Reset/clear:
  - rst or clr_i zeroes both counters, queue pointers, outstanding_o, mismatch_o and the mismatch data/lane registers, overflow_o and underflow_o.
  - throttle_o evaluates to 0 after reset/clear.
  - rst and clr_i override all same-cycle events.
- Injected counter: instr_in_o increments by 1 when instr_ack_i && count_en_i. Counts even when the push is dropped. Wraps modulo 2^CNT_W.
- Retired counter: instr_out_o increments by popcount(rvfi_valid_i) every cycle, regardless of count_en_i. Wraps modulo 2^CNT_W.
- Valid-lane contiguity: rvfi_valid_i lanes are contiguous from lane 0. Non-contiguous patterns are treated by popcount, in ascending lane order.
- Pop and compare (count_en_i=1 only):
  - n = popcount(rvfi_valid_i) entries pop.
  - Valid lanes are compared in ascending order against the queue head, head+1, and so on.
  - Only pre-cycle contents are visible: a same-cycle push is never popped or compared.
- Underflow:
  - If n > pre-cycle occupancy, pop all entries and compare only the lanes that have an entry. underflow_o sets (sticky).
  - Lanes without an entry generate no mismatch.
- Push (count_en_i=1, instr_ack_i=1): accepted if (occupancy - pops) < DEPTH, i.e. same-cycle pops free space. Otherwise the word is dropped, overflow_o sets (sticky), and occupancy is unchanged by the push.
- Occupancy: outstanding_o(next) = occupancy - pops + accepted_push. Pointers wrap modulo DEPTH.
- Mismatch reporting:
  - Registered; appears one cycle after the retire.
  - If any compared lane differs, mismatch_o=1 for exactly one cycle.
  - mismatch_lane_o/exp/got report the lowest mismatching lane and hold until the next mismatch or clear.
  - Entries pop whether or not they match.
- count_en_i=0: no push, pop, compare, underflow or overflow. Queue contents are retained. Only instr_out_o advances.
- throttle_o is combinational from registered occupancy; no input-to-output combinational path.

Test Plan:
- Reset/clear: drive stimulus, then assert rst for 1 cycle -> all outputs 0; repeat with clr_i during a simultaneous ack+retire -> all outputs 0, the event is ignored.
- Basic in-order check (NRET=1):
  - Inject 0x00000013, 0x00100093, 0x00200113; retire the same three words -> instr_in_o=3, instr_out_o=3, outstanding_o peaks at 3 and ends at 0, mismatch_o never asserts.
  - Retire 0x00300193 in place of the second word -> mismatch_o pulses once on the cycle after that retire, lane 0, exp=0x00100093, got=0x00300193.
- Multi-lane (NRET=2): queue 4 words, retire 2 lanes/cycle with lane 1 wrong in cycle 2 -> outstanding_o 4->2->0, mismatch_lane_o=1 with the correct exp/got.
- Full/overflow (DEPTH=8, THROTTLE=6):
  - Inject 6 -> throttle_o=1.
  - Inject to 8, then a 9th with no retire -> overflow_o=1, outstanding_o=8, instr_in_o=9.
  - At occupancy 8, do a push and 1 retire in the same cycle -> push accepted, occupancy stays 8, no new overflow.
- Underflow and enable:
  - count_en_i=1, empty queue, retire 1 -> underflow_o=1, instr_out_o=1, no mismatch.
  - count_en_i=0, ack 3 and retire 2 -> instr_in_o unchanged, instr_out_o += 2, queue untouched.
- Counter wrap (CNT_W=4): 17 acks -> instr_in_o=1; 16 retires -> instr_out_o=0.
